// File: rtl/ahfp_pkg.sv
// ahfp_pkg: shared FP field widths, slot-state encoding and operand field helpers
// for the shared-multiplier scheduler.
package ahfp_pkg;

    localparam int FP_W        = 32;
    localparam int FP_SIGN_W   = 1;
    localparam int FP_EXP_W    = 8;
    localparam int FP_MAN_W    = 23;
    localparam int FP_EXP_BIAS = 127;

    typedef enum logic [1:0] {
        SLOT_IDLE     = 2'd0,
        SLOT_PENDING  = 2'd1,
        SLOT_INFLIGHT = 2'd2
    } slot_state_e;

    typedef struct packed {
        logic [FP_SIGN_W-1:0] sign;
        logic [FP_EXP_W-1:0]  exp;
    } fp_se_t;

    function automatic fp_se_t fp_sign_exp(input logic [FP_W-1:0] op);
        fp_se_t se;
        se.sign = op[FP_W-1 -: FP_SIGN_W];
        se.exp  = op[FP_MAN_W +: FP_EXP_W];
        return se;
    endfunction

endpackage

// File: rtl/ahfp_rr_arb.sv
// ahfp_rr_arb: N-way round-robin arbiter; priority starts after the last grant and
// the pointer advances only when a grant is issued.
module ahfp_rr_arb #(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic             gnt_vld_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_vld_o = 1'b0;
        ptr_d     = ptr_q;
        idx       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'((int'(ptr_q) + k) % N_REQ);
            if (en_i && !gnt_vld_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_vld_o  = 1'b1;
                ptr_d      = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IDX_W'(N_REQ - 1);
        end else if (en_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ahfp_mult_sched.sv
// ahfp_mult_sched: shares one external FP multiplier among N_REQ start/done requesters.
// Optional AHFP_ZERO_BYPASS_EN forces a signed-zero result when an operand exponent is 0.
module ahfp_mult_sched
    import ahfp_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MULT_LAT = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic [N_REQ-1:0]    req_start,
    input  logic [32*N_REQ-1:0] req_dataa,
    input  logic [32*N_REQ-1:0] req_datab,
    output logic [N_REQ-1:0]    req_busy,
    output logic [N_REQ-1:0]    req_done,
    output logic [31:0]         req_result,
    output logic [31:0]         mult_dataa,
    output logic [31:0]         mult_datab,
    output logic                mult_valid,
    input  logic [31:0]         mult_result
);

    localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    slot_state_e      slot_q [N_REQ];
    slot_state_e      slot_d [N_REQ];
    logic [31:0]      opa_q  [N_REQ];
    logic [31:0]      opa_d  [N_REQ];
    logic [31:0]      opb_q  [N_REQ];
    logic [31:0]      opb_d  [N_REQ];

    logic [N_REQ-1:0] pend;
    logic [N_REQ-1:0] gnt;
    logic             gnt_vld;
    logic [TAG_W-1:0] gnt_idx;

    // Stage 0 is the issue register; stage MULT_LAT lines up with mult_result.
    logic [MULT_LAT:0] pv_q;
    logic [TAG_W-1:0]  ptag_q [MULT_LAT+1];

    logic [31:0]       dataa_q;
    logic [31:0]       datab_q;
    logic [N_REQ-1:0]  done_q;
    logic [N_REQ-1:0]  done_d;
    logic [31:0]       result_q;
    logic [31:0]       result_d;

    ahfp_rr_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (reset),
        .en_i      (clk_en),
        .req_i     (pend),
        .gnt_o     (gnt),
        .gnt_vld_o (gnt_vld)
    );

    always_comb begin
        pend     = '0;
        req_busy = '0;
        gnt_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pend[i]     = (slot_q[i] == SLOT_PENDING);
            req_busy[i] = (slot_q[i] != SLOT_IDLE);
            if (gnt[i]) begin
                gnt_idx = TAG_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            slot_d[i] = slot_q[i];
            opa_d[i]  = opa_q[i];
            opb_d[i]  = opb_q[i];
            unique case (slot_q[i])
                SLOT_IDLE: begin
                    if (req_start[i]) begin
                        slot_d[i] = SLOT_PENDING;
                        opa_d[i]  = req_dataa[32*i +: 32];
                        opb_d[i]  = req_datab[32*i +: 32];
                    end
                end
                SLOT_PENDING: begin
                    if (gnt[i]) begin
                        slot_d[i] = SLOT_INFLIGHT;
                    end
                end
                SLOT_INFLIGHT: begin
                    if (done_q[i]) begin
                        slot_d[i] = SLOT_IDLE;
                    end
                end
                default: slot_d[i] = SLOT_IDLE;
            endcase
        end
    end

`ifdef AHFP_ZERO_BYPASS_EN
    fp_se_t            se_a;
    fp_se_t            se_b;
    logic [MULT_LAT:0] pz_q;
    logic [MULT_LAT:0] psg_q;

    assign se_a = fp_sign_exp(opa_q[gnt_idx]);
    assign se_b = fp_sign_exp(opb_q[gnt_idx]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pz_q  <= '0;
            psg_q <= '0;
        end else if (clk_en) begin
            pz_q[0]  <= (se_a.exp == '0) || (se_b.exp == '0);
            psg_q[0] <= se_a.sign ^ se_b.sign;
            for (int k = 1; k <= MULT_LAT; k++) begin
                pz_q[k]  <= pz_q[k-1];
                psg_q[k] <= psg_q[k-1];
            end
        end
    end
`endif

    always_comb begin
        done_d   = '0;
        result_d = result_q;
        if (pv_q[MULT_LAT]) begin
            done_d[ptag_q[MULT_LAT]] = 1'b1;
            result_d                 = mult_result;
`ifdef AHFP_ZERO_BYPASS_EN
            if (pz_q[MULT_LAT]) begin
                result_d = {psg_q[MULT_LAT], 31'b0};
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                slot_q[i] <= SLOT_IDLE;
                opa_q[i]  <= '0;
                opb_q[i]  <= '0;
            end
            for (int k = 0; k <= MULT_LAT; k++) begin
                ptag_q[k] <= '0;
            end
            pv_q     <= '0;
            dataa_q  <= '0;
            datab_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
        end else if (clk_en) begin
            for (int i = 0; i < N_REQ; i++) begin
                slot_q[i] <= slot_d[i];
                opa_q[i]  <= opa_d[i];
                opb_q[i]  <= opb_d[i];
            end
            pv_q[0] <= gnt_vld;
            if (gnt_vld) begin
                ptag_q[0] <= gnt_idx;
                dataa_q   <= opa_q[gnt_idx];
                datab_q   <= opb_q[gnt_idx];
            end
            for (int k = 1; k <= MULT_LAT; k++) begin
                pv_q[k]   <= pv_q[k-1];
                ptag_q[k] <= ptag_q[k-1];
            end
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign mult_dataa = dataa_q;
    assign mult_datab = datab_q;
    assign mult_valid = pv_q[0];
    assign req_done   = done_q;
    assign req_result = result_q;

endmodule

// File: tb/tb_ahfp_mult_sched.sv
// tb_ahfp_mult_sched: two schedulers (MULT_LAT 0 and 3) driven in lockstep and checked
// against a slot/countdown reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_ahfp_mult_sched;

    localparam int N = 4;

    logic            clk    = 1'b0;
    logic            reset  = 1'b0;
    logic            clk_en = 1'b0;
    logic [N-1:0]    start  = '0;
    logic [32*N-1:0] da     = '0;
    logic [32*N-1:0] db     = '0;

    logic [N-1:0]    busy_o [2];
    logic [N-1:0]    done_o [2];
    logic [31:0]     res_o  [2];
    logic [31:0]     ma     [2];
    logic [31:0]     mb     [2];
    logic            mv     [2];
    logic [31:0]     mr     [2];
    logic [31:0]     mp1    [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Stand-in multiplier: normal operands only, truncating; zero-exponent inputs
    // return a qNaN marker so a raw pass-through is distinguishable from the bypass.
    function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'h7FC0_0000;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 10'd1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    function automatic logic [31:0] exp_res(input logic [31:0] a, input logic [31:0] b);
`ifdef AHFP_ZERO_BYPASS_EN
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'b0};
`endif
        return fpmul(a, b);
    endfunction

    assign mr[0] = fpmul(ma[0], mb[0]);
    always @(posedge clk) begin
        if (clk_en) begin
            mp1[0] <= fpmul(ma[1], mb[1]);
            mp1[1] <= mp1[0];
            mp1[2] <= mp1[1];
        end
    end
    assign mr[1] = mp1[2];

    ahfp_mult_sched #(.N_REQ(N), .MULT_LAT(0)) dut0 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .req_start(start),
        .req_dataa(da), .req_datab(db), .req_busy(busy_o[0]), .req_done(done_o[0]),
        .req_result(res_o[0]), .mult_dataa(ma[0]), .mult_datab(mb[0]),
        .mult_valid(mv[0]), .mult_result(mr[0])
    );

    ahfp_mult_sched #(.N_REQ(N), .MULT_LAT(3)) dut1 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .req_start(start),
        .req_dataa(da), .req_datab(db), .req_busy(busy_o[1]), .req_done(done_o[1]),
        .req_result(res_o[1]), .mult_dataa(ma[1]), .mult_datab(mb[1]),
        .mult_valid(mv[1]), .mult_result(mr[1])
    );

    // Reference model: 0 idle, 1 waiting for grant, 2 granted (countdown to done).
    int          LATS [2] = '{0, 3};
    int          mst  [2][N];
    int          rem  [2][N];
    logic [31:0] mopa [2][N];
    logic [31:0] mopb [2][N];
    logic [31:0] mres [2][N];
    int          ptr  [2];
    logic [N-1:0] edone [2];
    logic [31:0] eres [2];
    logic [31:0] ema  [2];
    logic        evalid [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < N; i++) begin
                mst[m][i] = 0;
                rem[m][i] = 0;
            end
            ptr[m]    = N - 1;
            edone[m]  = '0;
            eres[m]   = '0;
            evalid[m] = 1'b0;
        end
    endtask

    task automatic model_edge(input int m);
        logic [N-1:0] busy_pre, pend_pre, nd;
        int g, s;
        if (!clk_en) return;
        nd = '0;
        for (int i = 0; i < N; i++) begin
            busy_pre[i] = (mst[m][i] != 0);
            pend_pre[i] = (mst[m][i] == 1);
        end
        for (int i = 0; i < N; i++) begin
            if (mst[m][i] == 2 && rem[m][i] > 0) begin
                rem[m][i]--;
                if (rem[m][i] == 0) begin
                    nd[i]   = 1'b1;
                    eres[m] = mres[m][i];
                end
            end
        end
        for (int i = 0; i < N; i++) if (edone[m][i]) mst[m][i] = 0;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            s = (ptr[m] + k) % N;
            if (g < 0 && pend_pre[s]) g = s;
        end
        evalid[m] = (g >= 0);
        if (g >= 0) begin
            mst[m][g]  = 2;
            rem[m][g]  = LATS[m] + 1;
            mres[m][g] = exp_res(mopa[m][g], mopb[m][g]);
            ema[m]     = mopa[m][g];
            ptr[m]     = g;
        end
        for (int i = 0; i < N; i++) begin
            if (!busy_pre[i] && start[i]) begin
                mst[m][i]  = 1;
                mopa[m][i] = da[32*i +: 32];
                mopb[m][i] = db[32*i +: 32];
            end
        end
        edone[m] = nd;
    endtask

    task automatic step();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        start  = '0;
        clk_en = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int m = 0; m < 2; m++) begin
            checks++; if (busy_o[m] !== '0) begin errors++; $display("FAIL reset_busy[%0d]: got %h want 0", m, busy_o[m]); end
            checks++; if (done_o[m] !== '0) begin errors++; $display("FAIL reset_done[%0d]: got %h want 0", m, done_o[m]); end
            checks++; if (res_o[m] !== 32'h0) begin errors++; $display("FAIL reset_result[%0d]: got %h want 0", m, res_o[m]); end
            checks++; if (ma[m] !== 32'h0 || mb[m] !== 32'h0) begin errors++; $display("FAIL reset_mult_data[%0d]: got %h/%h want 0", m, ma[m], mb[m]); end
            checks++; if (mv[m] !== 1'b0) begin errors++; $display("FAIL reset_mult_valid[%0d]: got %b want 0", m, mv[m]); end
        end
    endtask

    task automatic test_single();
        logic [31:0] va [2] = '{32'h4000_0000, 32'hC000_0000};
        logic [31:0] vb [2] = '{32'h4040_0000, 32'h4080_0000};
        logic [31:0] vr [2] = '{32'h40C0_0000, 32'hC100_0000};
        for (int v = 0; v < 2; v++) begin
            do_reset();
            da[31:0] = va[v];
            db[31:0] = vb[v];
            start    = 4'b0001;
            step();
            start    = '0;
            for (int c = 1; c <= 8; c++) begin
                for (int m = 0; m < 2; m++) begin
                    checks++;
                    if (busy_o[m][0] !== (c <= 3 + LATS[m])) begin
                        errors++; $display("FAIL single_busy lat%0d edge+%0d: got %b want %b", LATS[m], c, busy_o[m][0], c <= 3 + LATS[m]);
                    end
                    checks++;
                    if (done_o[m] !== ((c == 3 + LATS[m]) ? 4'b0001 : 4'b0000)) begin
                        errors++; $display("FAIL single_done lat%0d edge+%0d: got %b", LATS[m], c, done_o[m]);
                    end
                    if (c == 3 + LATS[m]) begin
                        checks++;
                        if (res_o[m] !== vr[v]) begin
                            errors++; $display("FAIL single_result lat%0d: got %h want %h", LATS[m], res_o[m], vr[v]);
                        end
                    end
                end
                step();
            end
        end
    endtask

    task automatic test_all_four();
        logic [N-1:0] want;
        do_reset();
        for (int i = 0; i < N; i++) begin
            da[32*i +: 32] = 32'h3FC0_0000;
            db[32*i +: 32] = 32'h3FC0_0000;
        end
        start = 4'b1111;
        step();
        start = '0;
        for (int c = 1; c <= 11; c++) begin
            for (int m = 0; m < 2; m++) begin
                want = '0;
                if (c >= 3 + LATS[m] && c <= 6 + LATS[m]) want[c - 3 - LATS[m]] = 1'b1;
                checks++;
                if (done_o[m] !== want) begin
                    errors++; $display("FAIL all4_done lat%0d edge+%0d: got %b want %b", LATS[m], c, done_o[m], want);
                end
                if (want != '0) begin
                    checks++;
                    if (res_o[m] !== 32'h4010_0000) begin
                        errors++; $display("FAIL all4_result lat%0d: got %h want 40100000", LATS[m], res_o[m]);
                    end
                end
            end
            step();
        end
    endtask

    task automatic test_fairness();
        int cnt [2] = '{0, 0};
        logic [N-1:0] want;
        int sl;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            da[32*i +: 32] = 32'h3F80_0000 + (32'(i + 1) << 23);
            db[32*i +: 32] = 32'h4040_0000;
        end
        start = 4'b0111;
        for (int c = 0; c < 45; c++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                if (done_o[m] != '0) begin
                    sl   = cnt[m] % 3;
                    want = '0;
                    want[sl] = 1'b1;
                    checks++;
                    if (done_o[m] !== want || res_o[m] !== exp_res(da[32*sl +: 32], db[32*sl +: 32])) begin
                        errors++; $display("FAIL rr_order lat%0d #%0d: got %b/%h want %b", LATS[m], cnt[m], done_o[m], res_o[m], want);
                    end
                    cnt[m]++;
                end
            end
        end
        start = '0;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (cnt[m] < 9) begin
                errors++; $display("FAIL rr_starve lat%0d: got %0d dones want >=9", LATS[m], cnt[m]);
            end
        end
    endtask

    task automatic test_clk_en();
        do_reset();
        da[31:0] = 32'h4000_0000;
        db[31:0] = 32'h4040_0000;
        da[63:32] = 32'h3FC0_0000;
        db[63:32] = 32'h3FC0_0000;
        start = 4'b0001;
        step();
        start = '0;
        step();
        step();
        clk_en = 1'b0;
        start  = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (done_o[0] !== 4'b0001 || res_o[0] !== 32'h40C0_0000) begin
                errors++; $display("FAIL clken_stretch: got %b/%h want 0001/40c00000", done_o[0], res_o[0]);
            end
        end
        start  = '0;
        clk_en = 1'b1;
        step();
        checks++;
        if (done_o[0] !== 4'b0000 || busy_o[0] !== 4'b0000) begin
            errors++; $display("FAIL clken_release: got done %b busy %b want 0/0", done_o[0], busy_o[0]);
        end
        checks++;
        if (busy_o[1][1] !== 1'b0) begin
            errors++; $display("FAIL clken_drop_start: got busy %b want slot1 idle", busy_o[1]);
        end
        step();
        step();
        checks++;
        if (done_o[1] !== 4'b0001 || res_o[1] !== 32'h40C0_0000) begin
            errors++; $display("FAIL clken_freeze_lat3: got %b/%h want 0001/40c00000", done_o[1], res_o[1]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        da[31:0] = 32'h4000_0000;  db[31:0] = 32'h4040_0000;
        da[63:32] = 32'h3FC0_0000; db[63:32] = 32'h3FC0_0000;
        start = 4'b0011;
        step();
        start = '0;
        step();
        step();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (busy_o[m] !== '0 || done_o[m] !== '0 || res_o[m] !== '0 || mv[m] !== 1'b0 || ma[m] !== '0) begin
                errors++; $display("FAIL async_reset lat%0d: got busy %b done %b res %h mv %b", LATS[m], busy_o[m], done_o[m], res_o[m], mv[m]);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (done_o[m] !== '0 || busy_o[m] !== '0) begin
                    errors++; $display("FAIL post_reset_quiet lat%0d: got done %b busy %b", LATS[m], done_o[m], busy_o[m]);
                end
            end
        end
    endtask

    task automatic test_zero();
        logic [31:0] want;
        do_reset();
        da[31:0] = 32'h0000_0000;
        db[31:0] = 32'hC040_0000;
        want = exp_res(32'h0000_0000, 32'hC040_0000);
        start = 4'b0001;
        step();
        start = '0;
        for (int c = 1; c <= 7; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (c == 3 + LATS[m]) begin
                    checks++;
                    if (done_o[m] !== 4'b0001 || res_o[m] !== want) begin
                        errors++; $display("FAIL zero_operand lat%0d: got %b/%h want 0001/%h", LATS[m], done_o[m], res_o[m], want);
                    end
                end
            end
            step();
        end
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 7) == 0) r[30:23] = 8'd0;
        else r[30:23] = 8'($urandom_range(64, 190));
        return r;
    endfunction

    task automatic test_random();
        logic [N-1:0] ebusy;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            start  = N'($urandom);
            clk_en = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < N; i++) begin
                da[32*i +: 32] = rand_op();
                db[32*i +: 32] = rand_op();
            end
            step();
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < N; i++) ebusy[i] = (mst[m][i] != 0);
                checks++;
                if (done_o[m] !== edone[m] || busy_o[m] !== ebusy || mv[m] !== evalid[m]) begin
                    errors++; $display("FAIL rand_ctrl lat%0d cyc %0d: got done %b busy %b mv %b want %b %b %b",
                                       LATS[m], c, done_o[m], busy_o[m], mv[m], edone[m], ebusy, evalid[m]);
                end
                if (edone[m] != '0) begin
                    checks++;
                    if (res_o[m] !== eres[m]) begin
                        errors++; $display("FAIL rand_result lat%0d cyc %0d: got %h want %h", LATS[m], c, res_o[m], eres[m]);
                    end
                end
                if (evalid[m]) begin
                    checks++;
                    if (ma[m] !== ema[m]) begin
                        errors++; $display("FAIL rand_issue lat%0d cyc %0d: got %h want %h", LATS[m], c, ma[m], ema[m]);
                    end
                end
            end
        end
        clk_en = 1'b1;
        start  = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_clk_en();
        test_async_reset();
        test_zero();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahfp_mult_sched.md
Name: ahfp_mult_sched

Overview:
Shares one floating-point multiplier datapath among N_REQ requesters, each using a Nios-style start/done custom-instruction handshake. Requests are captured into per-requester slots and granted round-robin, at most one issue per cycle. Issued operands drive the external multiplier, and each result returns to its requester after a fixed latency. The block sits between the custom-instruction ports and a single multiplier instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
MULT_LAT, 0, pipeline depth of the attached multiplier in cycles (0 = combinational)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
clk_en  in  1  global enable; when low every register holds
req_start  in  N_REQ  per-requester 1-cycle start pulse
req_dataa  in  32*N_REQ  operand A, IEEE-754 single; slot i at [32i+31:32i]
req_datab  in  32*N_REQ  operand B, same packing as req_dataa
req_busy  out  N_REQ  slot i holds a pending or in-flight request
req_done  out  N_REQ  1-cycle pulse: req_result belongs to requester i
req_result  out  32  shared result bus, valid only while some req_done bit is high
mult_dataa  out  32  operand A to multiplier (registered)
mult_datab  out  32  operand B to multiplier (registered)
mult_valid  out  1  mult_dataa/mult_datab carry an issued request
mult_result  in  32  multiplier output, MULT_LAT cycles after issue

Behaviour:
- Reset values: req_busy=0, req_done=0, req_result=0, mult_dataa=0, mult_datab=0, mult_valid=0. Round-robin pointer = N_REQ-1, so slot 0 has priority first.
- Per-slot FSM with states IDLE, PENDING, INFLIGHT:
  - IDLE -> PENDING on req_start[i]; operands latched into the slot.
  - PENDING -> INFLIGHT when granted.
  - INFLIGHT -> IDLE in the cycle req_done[i] pulses.
- req_busy[i] is high in PENDING and INFLIGHT.
- A req_start[i] arriving while slot i is busy is ignored; no error flag is raised.
- Arbiter operates on PENDING slots:
  - Grants at most one slot per cycle.
  - Priority starts at the slot after the last granted slot and wraps from N_REQ-1 to 0.
  - The pointer updates only on a grant.
  - No grant leaves mult_valid low in the next cycle.
- Issue: on a grant, mult_dataa, mult_datab and mult_valid register the granted slot's operands on the next edge. The slot index is pushed into a tag/valid shift register of depth MULT_LAT.
- Capture: when the tag reaches the end of the shift register, the edge registers mult_result into req_result and pulses req_done[tag].
- Latency: start at edge t gives req_done at edge t+3+MULT_LAT, provided the slot is granted immediately.
- Throughput: 1 result per cycle when requests are back-to-back. Done pulses leave in grant order.
- A slot may re-start in the cycle after its done pulse.
- Simultaneous start and grant in the same cycle: a slot cannot be granted in the same cycle as its own start.
- clk_en low: all state, pointer, shift register and outputs freeze. A done pulse stretches until clk_en returns. Starts arriving while clk_en is low are dropped.
- Reset asserted mid-operation clears all slots and in-flight tags asynchronously; no done is emitted for discarded requests.
- Arithmetic is performed entirely by the external multiplier; this block does not modify the result except under the optional feature below.

Optional Feature:
AHFP_ZERO_BYPASS_EN.
- Defined: at issue, a zero flag is computed per request, set when either operand's exponent field is 0. The flag travels with the tag. At capture, a set flag substitutes {a_sign^b_sign, 31'b0} for mult_result. Latency is unchanged.
- Undefined: mult_result passes through unmodified, and no flag logic is present.

Decomposition:
- Shared package ahfp_pkg:
  - FP field widths (sign 1, exponent 8, mantissa 23)
  - exponent bias 127
  - slot-state encoding IDLE/PENDING/INFLIGHT
  - function extracting an operand's sign and exponent
- Sub-module ahfp_rr_arb: N-way round-robin grant. Inputs are a request vector and an enable; outputs are a one-hot grant and a grant-valid flag.

Test Plan:
- MULT_LAT=0; requester 0 issues 0x40000000 * 0x40400000 at edge t -> req_done[0] at t+3 with req_result=0x40C00000; req_busy[0] high for edges t+1 through t+3.
- All four requesters start in the same cycle with operands 0x3FC00000 * 0x3FC00000 -> grants go to slots 0,1,2,3 on consecutive cycles; four done pulses on consecutive cycles, each with req_result=0x40100000.
- Slot 2 re-starts every cycle while slots 0 and 1 are held pending -> grant order 0,1,2,0,1,2…; no requester starves.
- MULT_LAT=3; 0xC0000000 * 0x40800000 -> req_done at t+6 with req_result=0xC1000000.
- Reset driven low while two requests are in flight -> all outputs go to 0 immediately; no req_done is seen after reset is released.
- With AHFP_ZERO_BYPASS_EN defined: 0x00000000 * 0xC0400000 -> req_result=0x80000000 at normal latency. Without the macro, the raw mult_result is returned.
